// File: rtl/addr_seq_nb.sv
// Chunked multi-cycle adder: CHUNK bits of a+b+cin per cycle, carry registered between chunks.
// Latency: out_valid rises NCHUNK cycles after the accept edge; one op per NCHUNK+2 cycles.
// Backpressure: the result is held in DONE while out_ready is low; in_ready stays low until released.
module addr_seq_nb #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NCHUNK - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state, state_nxt;
    logic [IW-1:0]    idx;
    logic             carry;
    logic [WIDTH-1:0] a_q, b_q, sum_q;
    logic             cout_q, ovf_q;
    logic [CHUNK:0]   chunk_sum;
    logic             last;

    assign last      = (idx == LAST_IDX);
    assign chunk_sum = {1'b0, a_q[idx*CHUNK +: CHUNK]} + {1'b0, b_q[idx*CHUNK +: CHUNK]}
                     + {{CHUNK{1'b0}}, carry};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = CALC;
            CALC:    if (last)      state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx    <= '0;
            carry  <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q   <= a;
                        b_q   <= b;
                        carry <= cin;
                        idx   <= '0;
                    end
                end
                CALC: begin
                    sum_q[idx*CHUNK +: CHUNK] <= chunk_sum[CHUNK-1:0];
                    carry <= chunk_sum[CHUNK];
                    if (last) begin
                        // idx parks at 0 so the chunk select never points past the operand
                        idx    <= '0;
                        cout_q <= chunk_sum[CHUNK];
                        ovf_q  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                                  (chunk_sum[CHUNK-1] != a_q[WIDTH-1]);
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
endmodule

// File: doc/addr_seq_nb.md
Name: addr_seq_nb

Overview:
- Parametrised, multi-cycle successor to the team's 4-bit combinational ripple adder.
- Adds two WIDTH-bit operands plus carry-in over WIDTH/CHUNK clock cycles, processing CHUNK bits per cycle and registering the inter-chunk carry.
- Uses valid/ready handshakes on input and output, and adds signed-overflow detection.
- Serves as the area-lean adder for wide datapaths where single-cycle ripple timing is not met.

Parameters:
- WIDTH, 8, operand and sum width in bits; must be ≥1.
- CHUNK, 4, bits added per cycle; WIDTH must be an integer multiple of CHUNK. NCHUNK = WIDTH/CHUNK.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands and cin are valid
- in_ready  output  1  block can accept operands
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  (a+b+cin) mod 2^WIDTH
- cout  output  1  unsigned carry-out of the MSB
- ovf  output  1  two's-complement overflow
- busy  output  1  high in CALC or DONE

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; chunk index=0; carry reg=0.
  - Operand regs, sum, cout, ovf all 0.
  - in_ready=1, out_valid=0, busy=0.
  - Reset takes effect immediately, including mid-CALC or mid-DONE; any in-flight result is discarded.
- State IDLE:
  - in_ready=1.
  - On a clock edge with in_valid=1: capture a, b, cin; idx=0; carry=cin; go to CALC.
- State CALC (NCHUNK cycles), each edge:
  - Compute {c, s} = a[idx*CHUNK +: CHUNK] + b[idx*CHUNK +: CHUNK] + carry, in CHUNK+1-bit arithmetic.
  - Write s into sum[idx*CHUNK +: CHUNK]; carry=c; idx=idx+1.
  - On the edge processing idx=NCHUNK-1: set cout=c and ovf=(a[WIDTH-1]==b[WIDTH-1]) && (new sum[WIDTH-1]!=a[WIDTH-1]); go to DONE.
- State DONE:
  - out_valid=1; sum, cout and ovf are stable.
  - Stays in DONE while out_ready=0; outputs are held unchanged for the full stall.
  - On an edge with out_ready=1: go to IDLE, out_valid=0. sum/cout/ovf keep their last values but are don't-care.
- Latency:
  - Accept edge at T → out_valid high after edge T+NCHUNK.
  - With out_ready held high, next accept at edge T+NCHUNK+2 at the earliest.
  - Throughput is one operation per NCHUNK+2 cycles.
- in_ready is low in CALC and DONE; in_valid is ignored there. Operands are captured only at acceptance, so input changes after acceptance have no effect.
- NCHUNK=1 (CHUNK=WIDTH): CALC lasts exactly one cycle.
- sum partial bits during CALC are internal; out_valid=0 there and consumers must not sample.
- Wrap: sum is modulo 2^WIDTH. cout carries the lost bit. ovf is independent of cout.
- cin participates only in chunk 0; the carry reg is never reloaded mid-operation.

Test Plan:
1. WIDTH=8, CHUNK=4, a=0x0F, b=0x01, cin=0 → out_valid 2 cycles after accept; sum=0x10, cout=0, ovf=0 (carry crosses the chunk boundary).
2. WIDTH=8, CHUNK=4, a=0xFF, b=0x00, cin=1 → sum=0x00, cout=1, ovf=0. Then a=0x7F, b=0x01, cin=0 → sum=0x80, cout=0, ovf=1. Then a=0x80, b=0x80 → sum=0x00, cout=1, ovf=1.
3. Backpressure: complete an add, hold out_ready=0 for 5 cycles while toggling in_valid and a/b → out_valid, sum, cout, ovf unchanged; in_ready=0; no new accept. Raise out_ready → out_valid falls next edge and in_ready=1.
4. Reset mid-operation: accept 0xAA+0x55, assert rst_n=0 during the first CALC cycle → immediately out_valid=0, in_ready=1, sum=0, busy=0. Release reset → the next add works normally.
5. WIDTH=4, CHUNK=1: exhaustive over all 16×16×2 combinations of a, b, cin → each result has 4-cycle latency, {cout,sum}==a+b+cin, and ovf matches the signed check; back-to-back with out_ready=1 gives accepts spaced 6 cycles apart.
6. WIDTH=4, CHUNK=4 (NCHUNK=1): a=0x3, b=0x2, cin=1 → sum=0x6, cout=0, out_valid after exactly 1 CALC cycle.
